// File: rtl/regfile_wb_scheduler_if.sv
// Bundle between the scheduler and its neighbours: the writeback stage,
// the long-latency unit, decode and the register-file write port.
interface regfile_wb_scheduler_if;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;

    // Writeback stage
    logic              pipe_we;
    logic [REG_W-1:0]  pipe_rd;
    logic [DATA_W-1:0] pipe_wd;

    // Long-latency unit result channel
    logic              lu_valid;
    logic [REG_W-1:0]  lu_rd;
    logic [DATA_W-1:0] lu_wd;
    logic              lu_ready;

    // Decode side
    logic              issue_valid;
    logic [REG_W-1:0]  issue_rd;
    logic [REG_W-1:0]  chk_rs1;
    logic [REG_W-1:0]  chk_rs2;
    logic [REG_W-1:0]  chk_rd;
    logic              hazard;
    logic              issue_full;
    logic              stall_pipe;

    // Register-file write port and status
    logic              rf_we;
    logic [REG_W-1:0]  rf_a3;
    logic [DATA_W-1:0] rf_wd;
    logic [NREG-1:0]   busy_vec;
    logic              sb_err;

    // Surrounding pipeline / test driver
    modport master (
        output pipe_we, pipe_rd, pipe_wd,
        output lu_valid, lu_rd, lu_wd,
        output issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
        input  lu_ready, hazard, issue_full, stall_pipe,
        input  rf_we, rf_a3, rf_wd, busy_vec, sb_err
    );

    // The scheduler itself
    modport slave (
        input  pipe_we, pipe_rd, pipe_wd,
        input  lu_valid, lu_rd, lu_wd,
        input  issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
        output lu_ready, hazard, issue_full, stall_pipe,
        output rf_we, rf_a3, rf_wd, busy_vec, sb_err
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates the single WE3 port between
// the in-order writeback stage and an out-of-band long-latency unit, tracks
// in-flight long-op destinations in a scoreboard, and steals a writeback slot
// when the long unit has waited too long.
module regfile_wb_scheduler #(
    parameter int unsigned MAX_WAIT        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_scheduler_if.slave  bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic {
        ARB   = 1'b0,
        STEAL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic              err_q, err_d;

    logic              grant_lu;
    logic              grant_pipe;
    logic              xfer;
    logic              full;
    logic              accept;

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            wait_q  <= '0;
            busy_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // Arbitration FSM: grant selection, starvation counting, steal entry/exit
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        grant_lu   = 1'b0;
        grant_pipe = 1'b0;
        unique case (state_q)
            ARB: begin
                grant_pipe = bus.pipe_we;
                grant_lu   = !bus.pipe_we && bus.lu_valid;
                if (bus.lu_valid && !grant_lu) begin
                    if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                        state_d = STEAL;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            STEAL: begin
                // Pipeline is frozen; a single stolen slot, taken or not.
                grant_lu = bus.lu_valid;
                state_d  = ARB;
                wait_d   = '0;
            end
            default: begin
                state_d = ARB;
                wait_d  = '0;
            end
        endcase
    end

    assign xfer   = grant_lu;
    assign full   = (out_q == CNT_W'(MAX_OUTSTANDING));
    assign accept = bus.issue_valid && !full;

    // Scoreboard, outstanding counter and sticky error next-state
    always_comb begin
        busy_d = busy_q;
        out_d  = out_q;
        err_d  = err_q;
        if (xfer) begin
            if ((bus.lu_rd != REG_W'(0)) && !busy_q[bus.lu_rd]) begin
                err_d = 1'b1;
            end
            busy_d[bus.lu_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle set wins.
        if (accept && (bus.issue_rd != REG_W'(0))) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        unique case ({accept, xfer})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = (out_q == CNT_W'(0)) ? out_q : out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase
    end

    // Write-port mux and status outputs, all forced low while in reset
    always_comb begin
        bus.rf_we      = 1'b0;
        bus.rf_a3      = '0;
        bus.rf_wd      = '0;
        bus.lu_ready   = 1'b0;
        bus.stall_pipe = 1'b0;
        bus.hazard     = 1'b0;
        bus.issue_full = 1'b0;
        bus.busy_vec   = '0;
        bus.sb_err     = 1'b0;
        if (!rst) begin
            if (grant_lu) begin
                bus.rf_we    = 1'b1;
                bus.rf_a3    = bus.lu_rd;
                bus.rf_wd    = bus.lu_wd;
                bus.lu_ready = 1'b1;
            end else if (grant_pipe) begin
                bus.rf_we = 1'b1;
                bus.rf_a3 = bus.pipe_rd;
                bus.rf_wd = bus.pipe_wd;
            end
            bus.stall_pipe = (state_q == STEAL);
            bus.hazard     = busy_q[bus.chk_rs1] | busy_q[bus.chk_rs2] | busy_q[bus.chk_rd];
            bus.issue_full = full;
            bus.busy_vec   = busy_q;
            bus.sb_err     = err_q;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed stimulus, a behavioural model
// checked every cycle, plus hand-computed spot checks.
module tb_regfile_wb_scheduler;
    localparam int MAX_WAIT = 4;
    localparam int MAX_OUT  = 4;

    logic clk = 1'b0;
    logic rst;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler #(
        .MAX_WAIT        (MAX_WAIT),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: set of busy registers, in-flight count, starvation age
    bit [31:0] m_busy;
    int        m_out;
    int        m_age;
    bit        m_steal;
    bit        m_err;

    function automatic bit m_lu_granted();
        if (m_steal) return bus.lu_valid;
        return bus.lu_valid && !bus.pipe_we;
    endfunction

    // Advance the model at each active edge from the inputs seen that cycle
    always @(posedge clk) begin
        bit xfer;
        bit acc;
        if (rst) begin
            m_busy = 0; m_out = 0; m_age = 0; m_steal = 0; m_err = 0;
        end else begin
            xfer = m_lu_granted();
            acc  = bus.issue_valid && (m_out < MAX_OUT);
            if (xfer) begin
                if (bus.lu_rd != 0 && !m_busy[bus.lu_rd]) m_err = 1;
                m_busy[bus.lu_rd] = 0;
            end
            if (acc && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
            m_out = m_out + int'(acc) - int'(xfer);
            if (m_out < 0) m_out = 0;
            if (m_steal) begin
                m_steal = 0;
                m_age   = 0;
            end else if (bus.lu_valid && !xfer) begin
                m_age = m_age + 1;
                if (m_age >= MAX_WAIT) begin
                    m_steal = 1;
                    m_age   = 0;
                end
            end else begin
                m_age = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        bit        e_we;
        bit        e_rdy;
        bit [4:0]  e_a3;
        bit [31:0] e_wd;
        bit        e_haz;
        e_we = 0; e_rdy = 0; e_a3 = 0; e_wd = 0; e_haz = 0;
        if (!rst) begin
            if (m_lu_granted()) begin
                e_we = 1; e_rdy = 1; e_a3 = bus.lu_rd; e_wd = bus.lu_wd;
            end else if (!m_steal && bus.pipe_we) begin
                e_we = 1; e_a3 = bus.pipe_rd; e_wd = bus.pipe_wd;
            end
            e_haz = (bus.chk_rs1 != 0 && m_busy[bus.chk_rs1]) ||
                    (bus.chk_rs2 != 0 && m_busy[bus.chk_rs2]) ||
                    (bus.chk_rd  != 0 && m_busy[bus.chk_rd]);
        end
        chk("m_rf_we",      bus.rf_we,      e_we);
        chk("m_rf_a3",      bus.rf_a3,      e_a3);
        chk("m_rf_wd",      bus.rf_wd,      e_wd);
        chk("m_lu_ready",   bus.lu_ready,   e_rdy);
        chk("m_stall_pipe", bus.stall_pipe, !rst && m_steal);
        chk("m_hazard",     bus.hazard,     e_haz);
        chk("m_issue_full", bus.issue_full, !rst && (m_out == MAX_OUT));
        chk("m_busy_vec",   bus.busy_vec,   rst ? 32'h0 : m_busy);
        chk("m_sb_err",     bus.sb_err,     !rst && m_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        bus.pipe_we = 0; bus.pipe_rd = 0; bus.pipe_wd = 0;
        bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_wd = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
        bus.chk_rs1 = 0; bus.chk_rs2 = 0; bus.chk_rd = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.issue_valid = 1; bus.issue_rd = rd;
        tick();
        bus.issue_valid = 0; bus.issue_rd = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_wd = 32'h33;
        tick(); settle();
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_stall", bus.stall_pipe, 0);
        tick();
        rst = 0; idle();
        tick(); settle();
        chk("post_rst_busy", bus.busy_vec, 0);
        chk("post_rst_full", bus.issue_full, 0);

        // Priority, then starvation steal on x7
        issue(5'd7);
        bus.pipe_we = 1; bus.pipe_rd = 5; bus.pipe_wd = 32'hAA;
        bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_wd = 32'h77;
        settle();
        chk("prio_rf_we", bus.rf_we, 1);
        chk("prio_rf_a3", bus.rf_a3, 5);
        chk("prio_rf_wd", bus.rf_wd, 32'hAA);
        chk("prio_lu_ready", bus.lu_ready, 0);
        chk("prio_busy", bus.busy_vec, 32'h80);
        tick(); tick(); tick(); settle();
        chk("starve_c4_stall", bus.stall_pipe, 0);
        chk("starve_c4_ready", bus.lu_ready, 0);
        tick(); settle();
        chk("steal_stall", bus.stall_pipe, 1);
        chk("steal_rf_a3", bus.rf_a3, 7);
        chk("steal_rf_wd", bus.rf_wd, 32'h77);
        chk("steal_lu_ready", bus.lu_ready, 1);
        tick();
        bus.lu_valid = 0;
        settle();
        chk("after_steal_stall", bus.stall_pipe, 0);
        chk("after_steal_rf_a3", bus.rf_a3, 5);
        chk("after_steal_busy", bus.busy_vec, 0);
        chk("after_steal_err", bus.sb_err, 0);
        tick();
        idle();

        // Scoreboard hazard on x9 and x0 issue
        issue(5'd9);
        bus.chk_rs2 = 9;
        settle();
        chk("sb_hazard_set", bus.hazard, 1);
        chk("sb_busy9", bus.busy_vec, 32'h200);
        tick();
        bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_wd = 32'h99;
        settle();
        chk("sb_xfer9_ready", bus.lu_ready, 1);
        chk("sb_xfer9_hazard_still", bus.hazard, 1);
        tick();
        bus.lu_valid = 0;
        settle();
        chk("sb_hazard_clr", bus.hazard, 0);
        issue(5'd0);
        settle();
        chk("sb_x0_busy", bus.busy_vec, 0);
        bus.lu_valid = 1; bus.lu_rd = 0; bus.lu_wd = 32'h5;
        settle();
        chk("x0_xfer_rf_we", bus.rf_we, 1);
        chk("x0_xfer_a3", bus.rf_a3, 0);
        tick();
        idle();
        settle();
        chk("x0_xfer_err", bus.sb_err, 0);

        // Same-cycle set and clear of x3
        issue(5'd3);
        bus.lu_valid = 1; bus.lu_rd = 3; bus.lu_wd = 32'h3;
        bus.issue_valid = 1; bus.issue_rd = 3;
        tick();
        idle();
        settle();
        chk("setclr_busy3", bus.busy_vec, 32'h8);
        chk("setclr_full", bus.issue_full, 0);

        // Capacity: three more fill it, a fifth issue is dropped
        issue(5'd13); issue(5'd14); issue(5'd15);
        settle();
        chk("cap_full", bus.issue_full, 1);
        chk("cap_busy", bus.busy_vec, 32'hE008);
        issue(5'd16);
        settle();
        chk("cap_drop_busy", bus.busy_vec, 32'hE008);
        chk("cap_drop_full", bus.issue_full, 1);
        bus.lu_valid = 1; bus.lu_rd = 13; bus.lu_wd = 32'hD;
        tick();
        idle();
        settle();
        chk("cap_release_full", bus.issue_full, 0);
        chk("cap_release_busy", bus.busy_vec, 32'hC008);

        // Transfer to a non-busy register: sticky error
        bus.lu_valid = 1; bus.lu_rd = 12; bus.lu_wd = 32'hC;
        tick();
        idle();
        settle();
        chk("err_set", bus.sb_err, 1);
        tick(); tick(); tick(); settle();
        chk("err_sticky", bus.sb_err, 1);

        // Long unit drops valid during the stolen slot
        bus.pipe_we = 1; bus.pipe_rd = 2; bus.pipe_wd = 32'h22;
        bus.lu_valid = 1; bus.lu_rd = 14; bus.lu_wd = 32'hE;
        tick(); tick(); tick(); tick();
        bus.lu_valid = 0;
        settle();
        chk("drop_stall", bus.stall_pipe, 1);
        chk("drop_rf_we", bus.rf_we, 0);
        tick(); settle();
        chk("drop_exit_stall", bus.stall_pipe, 0);
        chk("drop_exit_a3", bus.rf_a3, 2);
        chk("drop_exit_busy", bus.busy_vec, 32'hC008);

        // Reset asserted while in STEAL
        bus.lu_valid = 1;
        tick(); tick(); tick(); tick(); settle();
        chk("rst_steal_pre", bus.stall_pipe, 1);
        rst = 1;
        #1;
        chk("rst_steal_rf_we", bus.rf_we, 0);
        tick();
        rst = 0; idle();
        settle();
        chk("rst_steal_stall", bus.stall_pipe, 0);
        chk("rst_steal_busy", bus.busy_vec, 0);
        chk("rst_steal_err", bus.sb_err, 0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
